// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and buffers up to two {instr, pc} entries.
// Latency: request accepted at cycle N with memory latency L -> instruction visible to the decoder at N+L+1.
// Backpressure: credit-based issue (buffer + in-flight <= 2), so responses are never stalled; out_ready gates buffer pops.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/ready/addr          fetch request channel (word-aligned address)
//   imem_rsp_valid/data                in-order fetch responses, at most one per cycle
//   redirect_valid/pc                  flush and restart fetch at redirect_pc (low 2 bits ignored)
//   out_valid/ready, output_instruction/pc   head of the output buffer toward the decoder

// Two-entry FIFO with synchronous clear; storage and pointers reset to zero so the head reads 0 after reset.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; callers guarantee no push when full and no pop when empty.
module if_stage_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clr) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_dat;
                r_wr        <= ~r_wr;
            end
            if (i_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head_dat = r_mem[r_rd];
    assign o_count    = r_count;
endmodule

module if_stage #(
    parameter int                    INSTRUCTION_WIDTH = 32,
    parameter int                    ADDR_WIDTH        = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] output_instruction,
    output logic [ADDR_WIDTH-1:0]        output_pc
);
    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]        pc;
    } fetch_ent_t;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [1:0]            r_drop;

    logic [ADDR_WIDTH-1:0] w_addr_head;
    logic [1:0]            w_outstanding;
    logic [1:0]            w_buf_count;
    fetch_ent_t            w_push_ent;
    fetch_ent_t            w_head_ent;
    logic [2:0]            w_used;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_buf_pop;
    logic                  w_rsp_keep;
    logic                  w_rsp_drop;
    logic [ADDR_WIDTH-1:0] w_redirect_aligned;

    assign w_redirect_aligned = redirect_pc & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    // A same-cycle pop frees a slot, so it counts toward credit; this is what
    // sustains one fetch per cycle at latency 1.
    assign w_buf_pop   = out_valid & out_ready;
    assign w_used      = {1'b0, w_buf_count} + {1'b0, w_outstanding};
    assign w_credit_ok = w_used < (3'd2 + {2'b00, w_buf_pop});

    // rst_n gating keeps the request low while reset is held and lets the
    // first fetch go out in the very first cycle after release.
    assign imem_req_valid = rst_n & w_credit_ok & ~redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_issue        = imem_req_valid & imem_req_ready;

    // A response in the redirect cycle is always stale and is discarded.
    assign w_rsp_keep = imem_rsp_valid & ~redirect_valid & (r_drop == 2'd0);
    assign w_rsp_drop = imem_rsp_valid & ~redirect_valid & (r_drop != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_aligned;
        end else if (w_issue) begin
            r_pc <= r_pc + ADDR_WIDTH'(4);
        end
    end

    // Every in-flight request at redirect time is stale, minus the one
    // returning in that very cycle (already discarded above).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 2'd0;
        end else if (redirect_valid) begin
            r_drop <= w_outstanding - {1'b0, imem_rsp_valid};
        end else if (w_rsp_drop) begin
            r_drop <= r_drop - 2'd1;
        end
    end

    // Issued-but-unreturned addresses; its occupancy is the outstanding count.
    // Never cleared on redirect: stale responses still arrive and must pop it.
    if_stage_fifo2 #(.W(ADDR_WIDTH)) u_addr_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (1'b0),
        .i_push     (w_issue),
        .i_push_dat (r_pc),
        .i_pop      (imem_rsp_valid),
        .o_head_dat (w_addr_head),
        .o_count    (w_outstanding)
    );

    assign w_push_ent = '{instr: imem_rsp_data, pc: w_addr_head};

    if_stage_fifo2 #(.W($bits(fetch_ent_t))) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (redirect_valid),
        .i_push     (w_rsp_keep),
        .i_push_dat (w_push_ent),
        .i_pop      (w_buf_pop),
        .o_head_dat (w_head_ent),
        .o_count    (w_buf_count)
    );

    assign out_valid          = (w_buf_count != 2'd0);
    assign output_instruction = w_head_ent.instr;
    assign output_pc          = w_head_ent.pc;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_instruction;
    logic [31:0] output_pc;

    if_stage dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_rsp_valid     (imem_rsp_valid),
        .imem_rsp_data      (imem_rsp_data),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .output_instruction (output_instruction),
        .output_pc          (output_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: returns addr + 0x1000_0000 exactly lat cycles after acceptance.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    int  cyc, lat, n_acc;
    bit  ready_g, ordy_g;
    int  n_pass, n_total;

    logic        s_req_vld, s_out_vld, s_acc, s_fire;
    logic [31:0] s_req_addr, s_out_pc, s_out_ins;

    task automatic step(input bit redir, input logic [31:0] rpc);
        mreq_t m;
        imem_req_ready = ready_g;
        out_ready      = ordy_g;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr + 32'h1000_0000;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_vld  = imem_req_valid;
        s_req_addr = imem_req_addr;
        s_out_vld  = out_valid;
        s_out_pc   = output_pc;
        s_out_ins  = output_instruction;
        s_acc      = imem_req_valid & imem_req_ready;
        s_fire     = out_valid & out_ready;
        if (s_acc) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        mq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        n_acc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (output_pc !== 32'h0) $display("FAIL reset_output_pc: got %h want 0", output_pc); else n_pass++;
        n_total++; if (output_instruction !== 32'h0) $display("FAIL reset_output_instr: got %h want 0", output_instruction); else n_pass++;
        n_total++; if (imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); else n_pass++;
    endtask

    task automatic test_stream();
        apply_reset();
        ready_g = 1; ordy_g = 1; lat = 1;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'h0);
            n_total++; if (s_req_vld !== 1'b1 || s_req_addr !== 32'(4 * i))
                $display("FAIL stream_req c%0d: got vld=%b addr=%h want vld=1 addr=%h", i, s_req_vld, s_req_addr, 32'(4 * i));
            else n_pass++;
            n_total++; if (s_out_vld !== (i >= 2))
                $display("FAIL stream_out_valid c%0d: got %b want %b", i, s_out_vld, (i >= 2));
            else n_pass++;
            if (i >= 2) begin
                n_total++; if (s_out_pc !== 32'(4 * (i - 2)) || s_out_ins !== 32'h1000_0000 + 32'(4 * (i - 2)))
                    $display("FAIL stream_out c%0d: got pc=%h ins=%h want pc=%h ins=%h", i, s_out_pc, s_out_ins,
                             32'(4 * (i - 2)), 32'h1000_0000 + 32'(4 * (i - 2)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[3];
        int cnt;
        apply_reset();
        ready_g = 1; ordy_g = 0; lat = 1;
        repeat (6) step(1'b0, 32'h0);
        n_total++; if (n_acc !== 2) $display("FAIL bp_req_count: got %0d want 2", n_acc); else n_pass++;
        n_total++; if (s_req_vld !== 1'b0) $display("FAIL bp_req_valid: got %b want 0", s_req_vld); else n_pass++;
        n_total++; if (s_out_vld !== 1'b1 || s_out_pc !== 32'h0)
            $display("FAIL bp_head: got vld=%b pc=%h want vld=1 pc=0", s_out_vld, s_out_pc);
        else n_pass++;
        ordy_g = 1;
        cnt = 0;
        for (int k = 0; k < 12 && cnt < 3; k++) begin
            step(1'b0, 32'h0);
            if (s_fire) begin got[cnt] = s_out_pc; cnt++; end
        end
        n_total++; if (cnt !== 3) $display("FAIL bp_drain_count: got %0d want 3", cnt); else n_pass++;
        n_total++; if (got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8)
            $display("FAIL bp_drain_order: got %h %h %h want 0 4 8", got[0], got[1], got[2]);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [31:0] acc[2];
        logic [31:0] opc[2];
        logic [31:0] oins;
        int na, no, nstale;
        apply_reset();
        ready_g = 1; ordy_g = 1; lat = 3;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        n_total++; if (s_req_vld !== 1'b0) $display("FAIL redir_no_req: got %b want 0", s_req_vld); else n_pass++;
        step(1'b0, 32'h0);
        n_total++; if (s_req_addr !== 32'h200) $display("FAIL redir_pc: got %h want 200", s_req_addr); else n_pass++;
        na = 0; no = 0; nstale = 0; oins = 32'h0;
        if (s_acc) begin acc[na] = s_req_addr; na++; end
        for (int k = 0; k < 20 && no < 2; k++) begin
            step(1'b0, 32'h0);
            if (s_acc && na < 2) begin acc[na] = s_req_addr; na++; end
            if (s_fire) begin
                if (s_out_pc < 32'h200) nstale++;
                else begin
                    if (no == 0) oins = s_out_ins;
                    opc[no] = s_out_pc; no++;
                end
            end
        end
        n_total++; if (nstale !== 0) $display("FAIL redir_stale: got %0d stale outputs want 0", nstale); else n_pass++;
        n_total++; if (na !== 2 || acc[0] !== 32'h200 || acc[1] !== 32'h204)
            $display("FAIL redir_reqs: got n=%0d %h %h want 200 204", na, acc[0], acc[1]);
        else n_pass++;
        n_total++; if (no !== 2 || opc[0] !== 32'h200 || oins !== 32'h1000_0200 || opc[1] !== 32'h204)
            $display("FAIL redir_out: got n=%0d pc0=%h ins0=%h pc1=%h want 200 10000200 204", no, opc[0], oins, opc[1]);
        else n_pass++;
    endtask

    task automatic test_stall();
        apply_reset();
        ready_g = 0; ordy_g = 1; lat = 1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            n_total++; if (s_req_vld !== 1'b1 || s_req_addr !== 32'h0 || s_out_vld !== 1'b0)
                $display("FAIL stall c%0d: got vld=%b addr=%h out_vld=%b want 1 0 0", i, s_req_vld, s_req_addr, s_out_vld);
            else n_pass++;
        end
        ready_g = 1;
        step(1'b0, 32'h0);
        n_total++; if (s_acc !== 1'b1 || s_req_addr !== 32'h0)
            $display("FAIL stall_release: got acc=%b addr=%h want 1 0", s_acc, s_req_addr);
        else n_pass++;
        step(1'b0, 32'h0);
        n_total++; if (s_req_addr !== 32'h4) $display("FAIL stall_next: got %h want 4", s_req_addr); else n_pass++;
    endtask

    task automatic test_misaligned();
        int no;
        logic [31:0] fpc, fins;
        apply_reset();
        ready_g = 1; ordy_g = 1; lat = 1;
        step(1'b0, 32'h0);
        step(1'b1, 32'h103);
        n_total++; if (s_req_vld !== 1'b0) $display("FAIL mis_no_req: got %b want 0", s_req_vld); else n_pass++;
        step(1'b0, 32'h0);
        n_total++; if (s_req_vld !== 1'b1 || s_req_addr !== 32'h100)
            $display("FAIL mis_addr: got vld=%b addr=%h want 1 100", s_req_vld, s_req_addr);
        else n_pass++;
        no = 0; fpc = 32'hFFFF_FFFF; fins = 32'h0;
        for (int k = 0; k < 10 && no == 0; k++) begin
            step(1'b0, 32'h0);
            if (s_fire) begin fpc = s_out_pc; fins = s_out_ins; no++; end
        end
        n_total++; if (fpc !== 32'h100 || fins !== 32'h1000_0100)
            $display("FAIL mis_first_out: got pc=%h ins=%h want 100 10000100", fpc, fins);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ready_g = 1; ordy_g = 0; lat = 1;
        repeat (5) step(1'b0, 32'h0);
        n_total++; if (s_out_vld !== 1'b1) $display("FAIL rmid_full: got out_vld=%b want 1", s_out_vld); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL rmid_during: got out_vld=%b req_vld=%b want 0 0", out_valid, imem_req_valid);
        else n_pass++;
        n_total++; if (output_pc !== 32'h0 || imem_req_addr !== 32'h0)
            $display("FAIL rmid_regs: got out_pc=%h req_addr=%h want 0 0", output_pc, imem_req_addr);
        else n_pass++;
        apply_reset();
        ordy_g = 1;
        step(1'b0, 32'h0);
        n_total++; if (s_req_vld !== 1'b1 || s_req_addr !== 32'h0)
            $display("FAIL rmid_restart: got vld=%b addr=%h want 1 0", s_req_vld, s_req_addr);
        else n_pass++;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        n_total++; if (s_out_vld !== 1'b1 || s_out_pc !== 32'h0)
            $display("FAIL rmid_first_out: got vld=%b pc=%h want 1 0", s_out_vld, s_out_pc);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        cyc = 0; lat = 1; n_acc = 0;
        ready_g = 0; ordy_g = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_stall();
        test_misaligned();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
